// File: rtl/axi_wr_cmd_queue.sv
// ---------------------------------------------------------------------------
// axi_wr_cmd_queue
//
// Queues single-beat AXI write commands {addr, data, strb} in a small FIFO
// and hands them one at a time to an AXI write master. A command is started
// with a one-cycle m_valid pulse. The next command is not popped until the
// master signals completion with a rising edge on m_done.
//
// Ports
//   ACLK       in   clock, rising edge
//   ARESET     in   asynchronous reset, active low
//   s_valid    in   producer offers a command
//   s_ready    out  queue not full
//   s_addr     in   [31:0] write byte address
//   s_data     in   [31:0] write data
//   s_strb     in   [3:0]  byte strobes
//   m_valid    out  one-cycle start pulse to the write master
//   m_addr     out  [31:0] command address, held until the next pop
//   m_data     out  [31:0] command data, held until the next pop
//   m_strb     out  [3:0]  command strobes, held until the next pop
//   m_done     in   master ready/completion level (rising edge = done)
//   count      out  number of queued entries
//   busy       out  a transaction is in flight (ISSUE or WAIT)
//   done_cnt   out  [15:0] completion counter, present only with
//                   AXI_WR_CMD_QUEUE_STATS_EN defined
//
// Build option: define AXI_WR_CMD_QUEUE_STATS_EN to add done_cnt.
// ---------------------------------------------------------------------------
module axi_wr_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [31:0]              s_addr,
    input  logic [31:0]              s_data,
    input  logic [3:0]               s_strb,
    output logic                     m_valid,
    output logic [31:0]              m_addr,
    output logic [31:0]              m_data,
    output logic [3:0]               m_strb,
    input  logic                     m_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
`ifdef AXI_WR_CMD_QUEUE_STATS_EN
   ,output logic [15:0]              done_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [67:0]     mem [DEPTH];
    logic            m_done_p1;
    logic            done_rise;
    logic            push;
    logic            pop;

    assign s_ready   = (count != FULL_C);
    assign push      = s_valid && s_ready;
    // Completion is an edge, not a level: the master may hold m_done high.
    assign done_rise = m_done && !m_done_p1;

    // Storage carries data only, so it has no reset.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[tail] <= {s_addr, s_data, s_strb};
        end
    end

    // Stage p0 -> p1: FIFO control, m_done history and the issued command.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            m_done_p1 <= 1'b0;
            m_addr    <= '0;
            m_data    <= '0;
            m_strb    <= '0;
        end else begin
            m_done_p1 <= m_done;
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
                {m_addr, m_data, m_strb} <= mem[head];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // FSM: state register.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = ISSUE;
            ISSUE:   state_nxt = done_rise ? IDLE : WAIT;
            WAIT:    if (done_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. ISSUE lasts exactly one cycle, so m_valid is a single pulse.
    always_comb begin
        pop     = (state == IDLE) && (count != '0);
        m_valid = (state == ISSUE);
        busy    = (state != IDLE);
    end

`ifdef AXI_WR_CMD_QUEUE_STATS_EN
    // Edges seen in IDLE are not completions and are not counted.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            done_cnt <= '0;
        end else if (done_rise && (state != IDLE)) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end
`endif

endmodule
